down_counter_timer: RTL

//   Loadable down-counter/interval timer, the counting-down counterpart of the team's
//   4-bit enable-gated up-counter. Software or a controller loads a start value; the block

---
 rtl/down_counter_timer.sv | 86 ++++++++
 1 files changed

// File: rtl/down_counter_timer.sv
// Loadable down-counter / interval timer with one-shot and auto-reload modes.
// The state is IDLE, RUN or DONE. Every output comes from a register, so no
// input reaches an output through combinational logic alone.
module down_counter_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] reload_reg;
  logic [WIDTH-1:0] reload_next;
  logic [WIDTH-1:0] out_next;
  logic             tc_next;
  logic             busy_next;
  logic             done_next;

  // State, reload value and output registers. Reset has the highest priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      reload_reg <= '0;
      out        <= '0;
      tc         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      reload_reg <= reload_next;
      out        <= out_next;
      tc         <= tc_next;
      busy       <= busy_next;
      done       <= done_next;
    end
  end

  // Next state and next count. Load takes priority over a count step, including a
  // count step on the terminal edge.
  always_comb begin
    state_next  = state;
    reload_next = reload_reg;
    out_next    = out;
    tc_next     = 1'b0;
    if (load) begin
      out_next    = load_value;
      reload_next = load_value;
      state_next  = (load_value != '0) ? RUN : IDLE;
    end else if (state == RUN && enable) begin
      if (out == WIDTH'(1)) begin
        tc_next = 1'b1;
        if (auto_reload) begin
          out_next = reload_reg;
        end else begin
          out_next   = '0;
          state_next = DONE;
        end
      end else if (out != '0) begin
        out_next = out - WIDTH'(1);
      end
    end
  end

  // Decode the status flags from the next state so that they are registered
  // together with that state.
  always_comb begin
    busy_next = (state_next == RUN);
    done_next = (state_next == DONE);
  end

endmodule
